// File: rtl/phy_reg_free_list_pkg.sv
// Shared physical-register constants and types
// used by the free list, register file and rename table.
package phy_reg_free_list_pkg;

    localparam int PHY_REGS  = 64;
    localparam int ARCH_REGS = 32;
    localparam int SICS      = 2;
    localparam int PRW       = $clog2(PHY_REGS);
    localparam int DEPTH     = PHY_REGS - ARCH_REGS;

    typedef logic [PRW-1:0] phy_reg_t;

endpackage

// File: rtl/phy_reg_free_list_if.sv
// Allocate/free port bundle between the rename
// requesters (master) and the free list (slave).
interface phy_reg_free_list_if
    import phy_reg_free_list_pkg::*;
#(
    parameter int NUM_SICS = SICS,
    parameter int W        = PRW
);

    logic [NUM_SICS-1:0]        alloc_req;
    logic [NUM_SICS-1:0]        alloc_gnt;
    logic [NUM_SICS-1:0]        alloc_wen;
    logic [NUM_SICS-1:0][W-1:0] alloc_pr;
    logic [NUM_SICS-1:0]        free_valid;
    logic [NUM_SICS-1:0][W-1:0] free_pr;

    modport master (
        output alloc_req,
        output free_valid,
        output free_pr,
        input  alloc_gnt,
        input  alloc_wen,
        input  alloc_pr
    );

    modport slave (
        input  alloc_req,
        input  free_valid,
        input  free_pr,
        output alloc_gnt,
        output alloc_wen,
        output alloc_pr
    );

endinterface

// File: rtl/phy_reg_free_list_rr_grant_select.sv
// Rotating-priority grant of up to avail slots
// among N requesters, with per-requester slot offset.
module phy_reg_free_list_rr_grant_select #(
    parameter int N   = 2,
    parameter int CW  = 4,
    parameter int RRW = 1
) (
    input  logic [N-1:0]         req,
    input  logic [RRW-1:0]       rr,
    input  logic [CW-1:0]        avail,
    output logic [N-1:0]         gnt,
    output logic [N-1:0][CW-1:0] slot,
    output logic [CW-1:0]        ngnt,
    output logic [RRW-1:0]       rr_nxt
);

    always_comb begin
        int k;
        int g;
        int j;
        int last;
        logic denied;
        logic [RRW-1:0] idx;
        gnt    = '0;
        slot   = '0;
        k      = 0;
        g      = 0;
        j      = 0;
        last   = int'(rr);
        denied = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(rr) + i;
            if (j >= N) j = j - N;
            idx = RRW'(j);
            // idle requesters consume no slot
            if (req[idx]) begin
                if (k < int'(avail)) begin
                    gnt[idx]  = 1'b1;
                    slot[idx] = CW'(k);
                    last      = j;
                    g         = g + 1;
                end else begin
                    denied = 1'b1;
                end
                k = k + 1;
            end
        end
        ngnt = CW'(g);
        j    = last + 1;
        if (j >= N) j = 0;
        rr_nxt = (denied && g > 0) ? RRW'(j) : rr;
    end

endmodule

// File: rtl/phy_reg_free_list.sv
// Physical register allocator: circular free list with
// multi-port rotating grant and retirement reclaim.
module phy_reg_free_list
    import phy_reg_free_list_pkg::*;
#(
    parameter int NUM_PHY_REGS  = PHY_REGS,
    parameter int NUM_SICS      = SICS,
    parameter int NUM_ARCH_REGS = ARCH_REGS
) (
    input  logic clk,
    input  logic rst,
    phy_reg_free_list_if.slave bus,
    output logic [$clog2(NUM_PHY_REGS-NUM_ARCH_REGS+1)-1:0] free_count,
    output logic empty
);

    localparam int DW   = NUM_PHY_REGS - NUM_ARCH_REGS;
    localparam int IW   = $clog2(NUM_PHY_REGS);
    localparam int CW   = $clog2(DW + 1);
    localparam int PTRW = DW > 1 ? $clog2(DW) : 1;
    localparam int RRW  = NUM_SICS > 1 ? $clog2(NUM_SICS) : 1;

    logic [IW-1:0]                 fifo [DW];
    logic [PTRW-1:0]               head;
    logic [PTRW-1:0]               tail;
    logic [CW-1:0]                 count;
    logic [CW-1:0]                 avail;
    logic [CW-1:0]                 ngnt;
    logic [CW-1:0]                 npush;
    logic [RRW-1:0]                rr;
    logic [RRW-1:0]                rr_nxt;
    logic [NUM_SICS-1:0]           gnt;
    logic [NUM_SICS-1:0]           push;
    logic [NUM_SICS-1:0][CW-1:0]   slot;
    logic [NUM_SICS-1:0][PTRW-1:0] wptr;

    // explicit wrap: DW need not be a power of two
    function automatic logic [PTRW-1:0] wrap(
        input logic [PTRW-1:0] base,
        input logic [CW-1:0]   off
    );
        int unsigned s;
        s = int'(base) + int'(off);
        return PTRW'(s % DW);
    endfunction

    // no grants while reset is held
    assign avail = rst ? '0 : count;

    phy_reg_free_list_rr_grant_select #(
        .N   (NUM_SICS),
        .CW  (CW),
        .RRW (RRW)
    ) u_sel (
        .req    (bus.alloc_req),
        .rr     (rr),
        .avail  (avail),
        .gnt    (gnt),
        .slot   (slot),
        .ngnt   (ngnt),
        .rr_nxt (rr_nxt)
    );

    assign bus.alloc_gnt = gnt;
    assign bus.alloc_wen = gnt;

    always_comb begin
        bus.alloc_pr = '0;
        for (int s = 0; s < NUM_SICS; s++) begin
            bus.alloc_pr[s] = fifo[wrap(head, slot[s])];
        end
    end

    always_comb begin
        push  = '0;
        wptr  = '0;
        npush = '0;
        for (int i = 0; i < NUM_SICS; i++) begin
            push[i] = bus.free_valid[i] &&
                      (int'(bus.free_pr[i]) >= NUM_ARCH_REGS);
            wptr[i] = wrap(tail, npush);
            if (push[i]) npush = npush + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DW; i++) begin
                fifo[i] <= IW'(NUM_ARCH_REGS + i);
            end
            head  <= '0;
            tail  <= '0;
            count <= CW'(DW);
            rr    <= '0;
        end else begin
            for (int i = 0; i < NUM_SICS; i++) begin
                if (push[i]) fifo[wptr[i]] <= bus.free_pr[i];
            end
            head  <= wrap(head, ngnt);
            tail  <= wrap(tail, npush);
            count <= count - ngnt + npush;
            rr    <= rr_nxt;
        end
    end

    assign free_count = count;
    assign empty      = (count == '0);

`ifndef SYNTHESIS
    logic [NUM_PHY_REGS-1:0] in_list;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_PHY_REGS; r++) begin
                in_list[r] <= (r >= NUM_ARCH_REGS);
            end
        end else begin
            for (int s = 0; s < NUM_SICS; s++) begin
                if (gnt[s]) in_list[bus.alloc_pr[s]] <= 1'b0;
            end
            for (int s = 0; s < NUM_SICS; s++) begin
                if (push[s]) in_list[bus.free_pr[s]] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (int'(count) - int'(ngnt) + int'(npush) <= DW)
            else $fatal(1, "free list overflow");
            for (int s = 0; s < NUM_SICS; s++) begin
                if (bus.free_valid[s]) begin
                    assert (int'(bus.free_pr[s]) < NUM_PHY_REGS)
                    else $fatal(1, "free_pr out of range");
                end
                if (push[s]) begin
                    assert (!in_list[bus.free_pr[s]])
                    else $fatal(1, "double free");
                    for (int t = s + 1; t < NUM_SICS; t++) begin
                        if (push[t]) begin
                            assert (bus.free_pr[s] != bus.free_pr[t])
                            else $fatal(1, "same register freed twice");
                        end
                    end
                end
            end
        end
    end
`endif

endmodule
